// File: rtl/noc_master_arbiter_if.sv
// noc_master_arbiter_if: request/grant and flit bus between processors, the arbiter and the router ports
interface noc_master_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int FLIT_W = 9,
  parameter int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
);
  logic [N_PORTS-1:0]        req_in;
  logic [PW*N_PORTS-1:0]     dest_in;
  logic [FLIT_W*N_PORTS-1:0] flit_in;
  logic [N_PORTS-1:0]        master_response;
  logic [FLIT_W*N_PORTS-1:0] flit_out;
  logic [N_PORTS-1:0]        valid_out;
  logic                      busy;
  logic                      abort_pulse;
  modport slave (
    input  req_in, dest_in, flit_in,
    output master_response, flit_out, valid_out, busy, abort_pulse
  );
  modport master (
    output req_in, dest_in, flit_in,
    input  master_response, flit_out, valid_out, busy, abort_pulse
  );
endinterface

// File: rtl/noc_master_arbiter.sv
// noc_master_arbiter: round-robin single-grant switch forwarding one source's flits to its destination until tlast
module noc_master_arbiter #(
  parameter int N_PORTS = 4,
  parameter int FLIT_W = 9,
  parameter int MAX_FLITS = 256
) (
  input logic clock,
  input logic reset,
  noc_master_arbiter_if.slave bus
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(MAX_FLITS);
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;
  state_t state;
  logic [PW-1:0] rr_ptr, src, dest, pick;
  logic [CW-1:0] flit_cnt;
  logic [FLIT_W-1:0] flit;
  logic timeout, last;
  assign flit = bus.flit_in[int'(src)*FLIT_W +: FLIT_W];
  assign timeout = flit_cnt == CW'(MAX_FLITS - 1);
  assign last = flit[FLIT_W-1] | timeout;
  assign bus.busy = state != IDLE;
  // Scan from the far end so the final hit is the first requester at or after rr_ptr.
  always_comb begin
    pick = '0;
    for (int k = N_PORTS - 1; k >= 0; k--)
      if (bus.req_in[(int'(rr_ptr) + k) % N_PORTS]) pick = PW'((int'(rr_ptr) + k) % N_PORTS);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      src <= '0;
      dest <= '0;
      flit_cnt <= '0;
      bus.master_response <= '0;
      bus.flit_out <= '0;
      bus.valid_out <= '0;
      bus.abort_pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.valid_out <= '0;
          bus.abort_pulse <= 1'b0;
          if (|bus.req_in) begin
            src <= pick;
            dest <= bus.dest_in[int'(pick)*PW +: PW];
            bus.master_response <= N_PORTS'(1) << pick;
            rr_ptr <= PW'((int'(pick) + 1) % N_PORTS);
            state <= XFER;
          end
        end
        XFER: begin
          bus.flit_out[int'(dest)*FLIT_W +: FLIT_W] <= {last, flit[FLIT_W-2:0]};
          bus.valid_out <= N_PORTS'(1) << dest;
          bus.abort_pulse <= timeout & ~flit[FLIT_W-1];
          flit_cnt <= timeout ? flit_cnt : flit_cnt + 1'b1;
          if (last) begin
            bus.master_response <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          bus.valid_out <= '0;
          bus.abort_pulse <= 1'b0;
          flit_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_master_arbiter.sv
// tb_noc_master_arbiter: directed cycle vectors plus timeout and async-reset sequences
module tb_noc_master_arbiter;
  logic clock = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  noc_master_arbiter_if bus ();
  noc_master_arbiter dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic [3:0] req;
    logic [7:0] dest;
    logic [35:0] flit;
    logic [3:0] resp;
    logic [3:0] vld;
    logic [8:0] fo;
    logic busy;
    logic abort;
  } vec_t;
  vec_t v[$];
  function automatic logic [35:0] f4(logic [8:0] a, logic [8:0] b, logic [8:0] c, logic [8:0] d);
    return {d, c, b, a};
  endfunction
  function automatic void add(logic [3:0] req, logic [7:0] dest, logic [35:0] flit, logic [3:0] resp,
                              logic [3:0] vld, logic [8:0] fo, logic busy, logic abort);
    vec_t r;
    r.req = req; r.dest = dest; r.flit = flit; r.resp = resp;
    r.vld = vld; r.fo = fo; r.busy = busy; r.abort = abort;
    v.push_back(r);
  endfunction
  function automatic int oh2i(logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction
  task automatic chk(string name, logic [35:0] act, logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fo_chk(string name, int idx, logic [8:0] exp);
    logic [35:0] fo;
    fo = bus.flit_out;
    chk(name, 36'(fo[idx*9 +: 9]), 36'(exp));
  endtask
  initial begin
    // round-robin: all four request, each sends two flits, src i -> dest (i+1)%4
    for (int b = 0; b < 5; b++) begin
      automatic int s = b % 4;
      automatic int d = (s + 1) % 4;
      automatic logic [35:0] b1 = f4(9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3);
      automatic logic [35:0] b2 = f4(9'h1B0, 9'h1B1, 9'h1B2, 9'h1B3);
      add(4'hF, 8'h39, b1, 4'(1 << s), 4'h0, 9'h0, 1, 0);
      add(4'hF, 8'h39, b1, 4'(1 << s), 4'(1 << d), 9'(9'h0A0 + s), 1, 0);
      add(4'hF, 8'h39, b2, 4'h0, 4'(1 << d), 9'(9'h1B0 + s), 1, 0);
      add((b == 4) ? 4'h0 : 4'hF, 8'h39, 36'h0, 4'h0, 4'h0, 9'h0, 0, 0);
    end
    // single transfer src0 -> dest2
    add(4'h1, 8'h02, 36'h0, 4'h1, 4'h0, 9'h0, 1, 0);
    add(4'h0, 8'h02, f4(9'h001, 0, 0, 0), 4'h1, 4'h4, 9'h001, 1, 0);
    add(4'h0, 8'h02, f4(9'h002, 0, 0, 0), 4'h1, 4'h4, 9'h002, 1, 0);
    add(4'h0, 8'h02, f4(9'h003, 0, 0, 0), 4'h1, 4'h4, 9'h003, 1, 0);
    add(4'h0, 8'h02, f4(9'h104, 0, 0, 0), 4'h0, 4'h4, 9'h104, 1, 0);
    add(4'h0, 8'h02, 36'h0, 4'h0, 4'h0, 9'h0, 0, 0);
    // stray request from src1 while src0 (dest3) transfers; src1 -> dest0
    add(4'h1, 8'h03, 36'h0, 4'h1, 4'h0, 9'h0, 1, 0);
    add(4'h3, 8'h03, f4(9'h011, 9'h155, 0, 0), 4'h1, 4'h8, 9'h011, 1, 0);
    add(4'h2, 8'h03, f4(9'h112, 9'h155, 0, 0), 4'h0, 4'h8, 9'h112, 1, 0);
    add(4'h2, 8'h03, f4(9'h000, 9'h155, 0, 0), 4'h0, 4'h0, 9'h0, 0, 0);
    add(4'h2, 8'h03, f4(9'h000, 9'h155, 0, 0), 4'h2, 4'h0, 9'h0, 1, 0);
    add(4'h0, 8'h03, f4(9'h000, 9'h1AA, 0, 0), 4'h0, 4'h1, 9'h1AA, 1, 0);
    add(4'h0, 8'h03, 36'h0, 4'h0, 4'h0, 9'h0, 0, 0);
    // loopback src3 -> dest3
    add(4'h8, 8'hC0, 36'h0, 4'h8, 4'h0, 9'h0, 1, 0);
    add(4'h0, 8'hC0, f4(0, 0, 0, 9'h1FF), 4'h0, 4'h8, 9'h1FF, 1, 0);
    add(4'h0, 8'hC0, 36'h0, 4'h0, 4'h0, 9'h0, 0, 0);
    bus.req_in = '0;
    bus.dest_in = '0;
    bus.flit_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_resp", 36'(bus.master_response), 36'h0);
    chk("reset_valid", 36'(bus.valid_out), 36'h0);
    chk("reset_busy", 36'(bus.busy), 36'h0);
    chk("reset_abort", 36'(bus.abort_pulse), 36'h0);
    chk("reset_flit_out", bus.flit_out, 36'h0);
    reset = 0;
    foreach (v[k]) begin
      bus.req_in = v[k].req;
      bus.dest_in = v[k].dest;
      bus.flit_in = v[k].flit;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_resp", k), 36'(bus.master_response), 36'(v[k].resp));
      chk($sformatf("v%0d_valid", k), 36'(bus.valid_out), 36'(v[k].vld));
      chk($sformatf("v%0d_busy", k), 36'(bus.busy), 36'(v[k].busy));
      chk($sformatf("v%0d_abort", k), 36'(bus.abort_pulse), 36'(v[k].abort));
      if (v[k].vld != 0) fo_chk($sformatf("v%0d_flit", k), oh2i(v[k].vld), v[k].fo);
    end
    // timeout: src2 -> dest1 never sends tlast
    bus.req_in = 4'h4;
    bus.dest_in = 8'h10;
    bus.flit_in = '0;
    @(posedge clock);
    #1;
    chk("to_grant", 36'(bus.master_response), 36'h4);
    bus.req_in = '0;
    for (int i = 0; i < 256; i++) begin
      bus.flit_in = f4(0, 0, {1'b0, 8'(i + 1)}, 0);
      @(posedge clock);
      #1;
      chk($sformatf("to%0d_valid", i), 36'(bus.valid_out), 36'h2);
      fo_chk($sformatf("to%0d_flit", i), 1, (i == 255) ? 9'h100 : {1'b0, 8'(i + 1)});
      chk($sformatf("to%0d_abort", i), 36'(bus.abort_pulse), (i == 255) ? 36'h1 : 36'h0);
      chk($sformatf("to%0d_resp", i), 36'(bus.master_response), (i == 255) ? 36'h0 : 36'h4);
    end
    bus.flit_in = '0;
    @(posedge clock);
    #1;
    chk("to_abort_drop", 36'(bus.abort_pulse), 36'h0);
    chk("to_gap_valid", 36'(bus.valid_out), 36'h0);
    @(posedge clock);
    #1;
    chk("to_idle_busy", 36'(bus.busy), 36'h0);
    // reset mid-burst with rr_ptr advanced past 0
    bus.req_in = 4'h4;
    bus.dest_in = 8'h00;
    @(posedge clock);
    #1;
    bus.req_in = '0;
    for (int i = 1; i <= 3; i++) begin
      bus.flit_in = f4(0, 0, 9'(9'h020 + i), 0);
      @(posedge clock);
      #1;
    end
    fo_chk("rst_pre_flit", 0, 9'h023);
    #2 reset = 1;
    #1;
    chk("rst_resp", 36'(bus.master_response), 36'h0);
    chk("rst_valid", 36'(bus.valid_out), 36'h0);
    chk("rst_busy", 36'(bus.busy), 36'h0);
    chk("rst_abort", 36'(bus.abort_pulse), 36'h0);
    chk("rst_flit_out", bus.flit_out, 36'h0);
    @(posedge clock);
    #1;
    reset = 0;
    bus.flit_in = '0;
    bus.req_in = 4'hA;
    @(posedge clock);
    #1;
    chk("rst_regrant", 36'(bus.master_response), 36'h2);
    chk("rst_regrant_busy", 36'(bus.busy), 36'h1);
    bus.req_in = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
